pipe_ctrl_chain: RTL and testbench



---
 rtl/pipe_ctrl_chain.sv | 159 +++++++++++++++
 tb/tb_pipe_ctrl_chain.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/pipe_ctrl_chain.sv
// pipe_ctrl_chain
//   Chain of NREG inter-stage pipeline registers with a built-in stall/flush
//   controller. Register k sits between stage k and stage k+1, and each one
//   carries a valid bit. The stage logic (decode, execute, memory) is outside
//   this module and connects through the flattened d_i / q_o buses.
//
//   Optional feature: define PIPE_PERF_CNT_EN to build the four 32-bit
//   performance counters. When it is undefined the counter ports are tied
//   to 0 and no counter flops are built.
//
// Ports
//   clk          rising-edge clock
//   rst          synchronous, active-high reset
//   stallreq_i   [NREG:0] stall request, bit s from stage s
//   flush_i      clear every stage register
//   in_valid_i   fetch stage holds a valid instruction
//   d_i          [NREG*DW-1:0] register k input at d_i[k*DW +: DW]
//   q_o          [NREG*DW-1:0] register k output at q_o[k*DW +: DW]
//   qv_o         [NREG-1:0] valid bit of register k
//   stall_o      [NREG:0] hold vector, bit s = stage s held
//   in_ready_o   fetch may advance (PC update enable)
//   cycle_cnt_o, stall_cnt_o, bubble_cnt_o, retire_cnt_o  performance counters

// One register slot: clear on reset or flush, then hold, then bubble, then load.
module pipe_ctrl_stage #(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush_i,
  input  logic          hold_i,
  input  logic          bubble_i,
  input  logic          uv_i,
  input  logic [DW-1:0] d_i,
  output logic [DW-1:0] q_o,
  output logic          qv_o
);
  logic [DW-1:0] q_q, q_d;
  logic          v_q, v_d;

  always_comb begin
    q_d = d_i;
    v_d = uv_i;
    if (flush_i || bubble_i) begin
      // A bubble is an all-zero word (the MIPS NOP) and is never stale data.
      q_d = '0;
      v_d = 1'b0;
    end else if (hold_i) begin
      q_d = q_q;
      v_d = v_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q_q <= '0;
      v_q <= 1'b0;
    end else begin
      q_q <= q_d;
      v_q <= v_d;
    end
  end

  assign q_o  = q_q;
  assign qv_o = v_q;
endmodule

module pipe_ctrl_chain #(
  parameter int NREG = 4,
  parameter int DW   = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NREG:0]    stallreq_i,
  input  logic             flush_i,
  input  logic             in_valid_i,
  input  logic [NREG*DW-1:0] d_i,
  output logic [NREG*DW-1:0] q_o,
  output logic [NREG-1:0]  qv_o,
  output logic [NREG:0]    stall_o,
  output logic             in_ready_o,
  output logic [31:0]      cycle_cnt_o,
  output logic [31:0]      stall_cnt_o,
  output logic [31:0]      bubble_cnt_o,
  output logic [31:0]      retire_cnt_o
);
  logic [NREG:0]   stall;
  logic [NREG-1:0] hold, bub, qv;

  // A stall request from stage s holds s and every stage upstream of it.
  // This is a suffix-OR that depends only on stallreq_i, so there is no path
  // from q_o to stall_o.
  always_comb begin
    stall       = '0;
    stall[NREG] = stallreq_i[NREG];
    for (int s = NREG - 1; s >= 0; s--) stall[s] = stallreq_i[s] | stall[s+1];
  end

  assign stall_o    = stall;
  assign in_ready_o = ~stall[0];

  for (genvar k = 0; k < NREG; k++) begin : g_reg
    logic uv;
    // Stall on both sides means the register holds. Stall only on the
    // upstream side means the held stage meets a moving one, so a bubble
    // is inserted.
    assign hold[k] = stall[k] & stall[k+1];
    assign bub[k]  = stall[k] & ~stall[k+1];

    if (k == 0) begin : g_uv0
      assign uv = in_valid_i;
    end else begin : g_uvk
      assign uv = qv[k-1];
    end

    pipe_ctrl_stage #(.DW(DW)) u_stage (
      .clk      (clk),
      .rst      (rst),
      .flush_i  (flush_i),
      .hold_i   (hold[k]),
      .bubble_i (bub[k]),
      .uv_i     (uv),
      .d_i      (d_i[k*DW +: DW]),
      .q_o      (q_o[k*DW +: DW]),
      .qv_o     (qv[k])
    );
  end

  assign qv_o = qv;

`ifdef PIPE_PERF_CNT_EN
  logic [31:0] cyc_q, stl_q, bub_q, ret_q;

  // Only rst clears the counters; a flush leaves them running.
  always_ff @(posedge clk) begin
    if (rst) begin
      cyc_q <= '0;
      stl_q <= '0;
      bub_q <= '0;
      ret_q <= '0;
    end else begin
      cyc_q <= cyc_q + 32'd1;
      if (stall[0])             stl_q <= stl_q + 32'd1;
      if (!flush_i && (|bub))   bub_q <= bub_q + 32'd1;
      if (qv[NREG-1] && !stall[NREG]) ret_q <= ret_q + 32'd1;
    end
  end

  assign cycle_cnt_o  = cyc_q;
  assign stall_cnt_o  = stl_q;
  assign bubble_cnt_o = bub_q;
  assign retire_cnt_o = ret_q;
`else
  assign cycle_cnt_o  = '0;
  assign stall_cnt_o  = '0;
  assign bubble_cnt_o = '0;
  assign retire_cnt_o = '0;
`endif
endmodule

// File: tb/tb_pipe_ctrl_chain.sv
// Bench for pipe_ctrl_chain: a queue-style reference model plus directed
// scenarios, with literal expectations that pin the model itself.
module tb_pipe_ctrl_chain;
  localparam int NREG = 4;
  localparam int DW   = 32;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic [NREG:0]      stallreq = '0;
  logic               flush = 1'b0;
  logic               in_valid = 1'b0;
  logic [DW-1:0]      fetch_d = '0;
  logic [NREG*DW-1:0] d_i;
  logic [NREG*DW-1:0] q_o;
  logic [NREG-1:0]    qv_o;
  logic [NREG:0]      stall_o;
  logic               in_ready_o;
  logic [31:0]        cyc_o, stl_o, bub_o, ret_o;

  // Downstream stage logic is a pass-through: register k is fed by q_o[k-1].
  assign d_i = {q_o[(NREG-1)*DW-1:0], fetch_d};

  pipe_ctrl_chain #(.NREG(NREG), .DW(DW)) dut (
    .clk(clk), .rst(rst), .stallreq_i(stallreq), .flush_i(flush),
    .in_valid_i(in_valid), .d_i(d_i), .q_o(q_o), .qv_o(qv_o),
    .stall_o(stall_o), .in_ready_o(in_ready_o),
    .cycle_cnt_o(cyc_o), .stall_cnt_o(stl_o), .bubble_cnt_o(bub_o), .retire_cnt_o(ret_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: one slot per register, updated by the stage rules.
  logic [DW-1:0]   mq [NREG];
  logic [NREG-1:0] mv = '0;
  logic [31:0]     mcyc = 0, mstl = 0, mbub = 0, mret = 0;
  bit              started = 0;

  // Returns the index of the highest stage requesting a stall, or -1 if none.
  function automatic int hi_req(input logic [NREG:0] r);
    int h = -1;
    for (int s = 0; s <= NREG; s++) if (r[s]) h = s;
    return h;
  endfunction

  always @(posedge clk) begin
    logic [DW-1:0]   nq [NREG];
    logic [NREG-1:0] nv;
    int h;
    if (rst) begin
      for (int k = 0; k < NREG; k++) mq[k] = '0;
      mv = '0; mcyc = 0; mstl = 0; mbub = 0; mret = 0;
      started = 1;
    end else begin
      h = hi_req(stallreq);
      for (int k = 0; k < NREG; k++) begin
        if (flush)       begin nq[k] = '0;    nv[k] = 1'b0;  end
        else if (k < h)  begin nq[k] = mq[k]; nv[k] = mv[k]; end
        else if (k == h) begin nq[k] = '0;    nv[k] = 1'b0;  end
        else if (k == 0) begin nq[k] = fetch_d; nv[k] = in_valid; end
        else             begin nq[k] = mq[k-1]; nv[k] = mv[k-1]; end
      end
      mcyc = mcyc + 1;
      if (h >= 0) mstl = mstl + 1;
      if (!flush && h >= 0 && h < NREG) mbub = mbub + 1;
      if (mv[NREG-1] && h < NREG) mret = mret + 1;
      for (int k = 0; k < NREG; k++) mq[k] = nq[k];
      mv = nv;
    end
  end

  // Compare process: every cycle, away from the active edge.
  always @(negedge clk) begin
    logic [NREG:0] es;
    int h;
    h = hi_req(stallreq);
    for (int j = 0; j <= NREG; j++) es[j] = (j <= h);
    chk("stall_o", 256'(stall_o), 256'(es));
    chk("in_ready_o", 256'(in_ready_o), 256'(h < 0));
    if (started) begin
      for (int k = 0; k < NREG; k++) chk($sformatf("q_o[%0d]", k), 256'(q_o[k*DW +: DW]), 256'(mq[k]));
      chk("qv_o", 256'(qv_o), 256'(mv));
`ifdef PIPE_PERF_CNT_EN
      chk("cycle_cnt", 256'(cyc_o), 256'(mcyc));
      chk("stall_cnt", 256'(stl_o), 256'(mstl));
      chk("bubble_cnt", 256'(bub_o), 256'(mbub));
      chk("retire_cnt", 256'(ret_o), 256'(mret));
`else
      chk("cnt_tied0", 256'({cyc_o, stl_o, bub_o, ret_o}), 256'(0));
`endif
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [DW-1:0]      words [6] = '{32'h11, 32'h22, 32'h33, 32'h44, 32'h55, 32'h66};
  logic [NREG*DW-1:0] snap_q;
  logic [NREG-1:0]    snap_v;

  initial begin
    // Reset with random fetch data.
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin fetch_d = $urandom; in_valid = 1'b1; tick(); end
    chk("rst_q", 256'(q_o), 256'(0));
    chk("rst_qv", 256'(qv_o), 256'(0));
    chk("rst_cnt", 256'({cyc_o, stl_o, bub_o, ret_o}), 256'(0));

    // Counters: 10 cycles with an EX stall on cycles 3 to 5.
    rst = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      stallreq = (c >= 3 && c <= 5) ? 5'b00100 : 5'b00000;
      fetch_d = $urandom;
      tick();
    end
    stallreq = '0;
`ifdef PIPE_PERF_CNT_EN
    chk("lit_cycle10", 256'(cyc_o), 256'(10));
    chk("lit_stall3", 256'(stl_o), 256'(3));
    chk("lit_bubble3", 256'(bub_o), 256'(3));
`else
    chk("lit_cnt0", 256'({cyc_o, stl_o, bub_o}), 256'(0));
`endif

    // Flow: fill the pipe from empty.
    rst = 1'b1; tick(); rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      fetch_d = words[i]; in_valid = 1'b1;
      tick();
      if (i == 3) begin
        chk("lit_fill_q3", 256'(q_o[3*DW +: DW]), 256'(32'h11));
        chk("lit_fill_v3", 256'(qv_o[3]), 256'(1));
      end
      if (i == 4) chk("lit_next_q3", 256'(q_o[3*DW +: DW]), 256'(32'h22));
    end

    // EX stall for one cycle with the pipe full.
    fetch_d = words[5]; stallreq = 5'b00100; #1;
    chk("lit_ex_stall_o", 256'(stall_o), 256'(5'b00111));
    chk("lit_ex_ready", 256'(in_ready_o), 256'(0));
    tick();
    chk("lit_ex_q0", 256'(q_o[0 +: DW]), 256'(32'h55));
    chk("lit_ex_q1", 256'(q_o[DW +: DW]), 256'(32'h44));
    chk("lit_ex_q2", 256'(q_o[2*DW +: DW]), 256'(0));
    chk("lit_ex_q3", 256'(q_o[3*DW +: DW]), 256'(32'h33));
    chk("lit_ex_qv", 256'(qv_o), 256'(4'b1011));

    // WB stall for three cycles: everything holds and no bubble appears.
    stallreq = 5'b10000; #1;
    chk("lit_wb_stall_o", 256'(stall_o), 256'(5'b11111));
    snap_q = q_o; snap_v = qv_o;
    for (int i = 0; i < 3; i++) begin
      fetch_d = $urandom;
      tick();
      chk("lit_wb_hold_q", 256'(q_o), 256'(snap_q));
      chk("lit_wb_hold_v", 256'(qv_o), 256'(snap_v));
    end
    stallreq = '0; tick(); tick();

    // Flush during a stall.
    flush = 1'b1; stallreq = 5'b00010; #1;
    chk("lit_fl_ready", 256'(in_ready_o), 256'(0));
    tick();
    chk("lit_fl_q", 256'(q_o), 256'(0));
    chk("lit_fl_qv", 256'(qv_o), 256'(0));
    flush = 1'b0; stallreq = '0;

    // Random traffic, checked by the model.
    for (int i = 0; i < 40; i++) begin
      fetch_d  = $urandom;
      in_valid = $urandom_range(0, 1);
      stallreq = ($urandom_range(0, 3) == 0) ? (5'b00001 << $urandom_range(0, NREG)) : 5'b0;
      flush    = ($urandom_range(0, 15) == 0);
      tick();
    end

    // Reset mid-operation overrides flush and stall.
    rst = 1'b1; flush = 1'b1; stallreq = 5'b10000; tick();
    chk("lit_midrst_q", 256'(q_o), 256'(0));
    chk("lit_midrst_qv", 256'(qv_o), 256'(0));
    chk("lit_midrst_cnt", 256'({cyc_o, stl_o, bub_o, ret_o}), 256'(0));
    rst = 1'b0; flush = 1'b0; stallreq = '0;
    tick(); tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
